// File: rtl/aes_loader_pkg.sv
// Shared constants and state encoding for the AES block loader.
package aes_loader_pkg;
  localparam int WORD_W    = 32;
  localparam int KEY_WORDS = 8;
  localparam int PT_WORDS  = 4;
  localparam int CT_WORDS  = PT_WORDS;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_KEY = 3'd1,
    ST_LOAD_PT  = 3'd2,
    ST_START    = 3'd3,
    ST_RUN      = 3'd4,
    ST_UNLOAD   = 3'd5
  } state_e;
endpackage

// File: rtl/aes_block_loader_if.sv
// Word-stream and AES-core signals of the block loader, grouped as one bundle.
interface aes_block_loader_if;
  import aes_loader_pkg::*;

  logic                       in_valid_i;
  logic                       in_ready_o;
  logic [WORD_W-1:0]          in_data_i;
  logic                       in_key_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [WORD_W-1:0]          out_data_o;
  logic [KEY_WORDS*WORD_W-1:0] core_key_o;
  logic [PT_WORDS*WORD_W-1:0] core_plaintext_o;
  logic                       core_en_o;
  logic                       core_rst_n_o;
  logic                       core_done_i;
  logic [CT_WORDS*WORD_W-1:0] core_ciphertext_i;
  logic                       busy_o;
  logic                       err_o;

  modport slave (
    input  in_valid_i, in_data_i, in_key_i, out_ready_i, core_done_i, core_ciphertext_i,
    output in_ready_o, out_valid_o, out_data_o, core_key_o, core_plaintext_o,
           core_en_o, core_rst_n_o, busy_o, err_o
  );

  modport master (
    output in_valid_i, in_data_i, in_key_i, out_ready_i, core_done_i, core_ciphertext_i,
    input  in_ready_o, out_valid_o, out_data_o, core_key_o, core_plaintext_o,
           core_en_o, core_rst_n_o, busy_o, err_o
  );
endinterface

// File: rtl/aes_word_sipo.sv
// Serial-in/parallel-out word register; word 0 lands in the most significant slot.
module aes_word_sipo
  import aes_loader_pkg::*;
#(
  parameter int N_WORDS = PT_WORDS,
  parameter int W       = WORD_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [$clog2(N_WORDS)-1:0] idx_i,
  input  logic [W-1:0]               data_i,
  output logic [N_WORDS*W-1:0]       data_o
);
  logic [N_WORDS*W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (wr_en_i) data_d[(N_WORDS-1-int'(idx_i))*W +: W] = data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) data_q <= '0;
    else       data_q <= data_d;
  end

  assign data_o = data_q;
endmodule

// File: rtl/aes_block_loader.sv
// Loads key/plaintext words into an AES core, runs it with a timeout and streams out the ciphertext.
//   state    | meaning
//   IDLE     | waiting for the first word of a key or plaintext block
//   LOAD_KEY | collecting key words 1..7
//   LOAD_PT  | collecting plaintext words 1..3
//   START    | one-cycle core restart pulse
//   RUN      | core enabled, waiting for done or timeout
//   UNLOAD   | handing out the four ciphertext words
module aes_block_loader
  import aes_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk_i,
  input  logic rst_i,
  aes_block_loader_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] IDLE     = ST_IDLE;
  localparam logic [2:0] LOAD_KEY = ST_LOAD_KEY;
  localparam logic [2:0] LOAD_PT  = ST_LOAD_PT;
  localparam logic [2:0] START    = ST_START;
  localparam logic [2:0] RUN      = ST_RUN;
  localparam logic [2:0] UNLOAD   = ST_UNLOAD;

  logic [2:0]                   state_q, state_d;
  logic [2:0]                   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]             cyc_q, cyc_d;
  logic                         key_valid_q, key_valid_d;
  logic [CT_WORDS*WORD_W-1:0]   ct_q, ct_d;
  logic [KEY_WORDS*WORD_W-1:0]  key_q;
  logic [PT_WORDS*WORD_W-1:0]   pt_q;
  logic in_ready, in_fire, out_fire, key_wr, pt_wr, timeout, idle_err;

  assign in_ready = (state_q == IDLE) || (state_q == LOAD_KEY) || (state_q == LOAD_PT);
  assign in_fire  = bus.in_valid_i && in_ready;
  assign out_fire = (state_q == UNLOAD) && bus.out_ready_i;
  // in_key_i only matters on the first word of a block, i.e. while in IDLE
  assign key_wr   = in_fire && (((state_q == IDLE) && bus.in_key_i) || (state_q == LOAD_KEY));
  assign pt_wr    = in_fire && (((state_q == IDLE) && !bus.in_key_i && key_valid_q) ||
                                (state_q == LOAD_PT));
  assign idle_err = in_fire && (state_q == IDLE) && !bus.in_key_i && !key_valid_q;
  assign timeout  = (state_q == RUN) && !bus.core_done_i && (cyc_q == CNT_W'(TIMEOUT_CYCLES));

  aes_word_sipo #(.N_WORDS(KEY_WORDS), .W(WORD_W)) u_key_sipo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en_i (key_wr),
    .idx_i   (wcnt_q),
    .data_i  (bus.in_data_i),
    .data_o  (key_q)
  );

  aes_word_sipo #(.N_WORDS(PT_WORDS), .W(WORD_W)) u_pt_sipo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en_i (pt_wr),
    .idx_i   (wcnt_q[1:0]),
    .data_i  (bus.in_data_i),
    .data_o  (pt_q)
  );

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    cyc_d       = cyc_q;
    key_valid_d = key_valid_q;
    ct_d        = ct_q;
    case (state_q)
      IDLE: begin
        if (key_wr) begin
          state_d     = LOAD_KEY;
          wcnt_d      = 3'd1;
          key_valid_d = 1'b0;
        end else if (pt_wr) begin
          state_d = LOAD_PT;
          wcnt_d  = 3'd1;
        end
      end
      LOAD_KEY: begin
        if (in_fire) begin
          if (wcnt_q == 3'(KEY_WORDS - 1)) begin
            state_d     = IDLE;
            wcnt_d      = '0;
            key_valid_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 3'd1;
          end
        end
      end
      LOAD_PT: begin
        if (in_fire) begin
          if (wcnt_q == 3'(PT_WORDS - 1)) begin
            state_d = START;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 3'd1;
          end
        end
      end
      START: begin
        state_d = RUN;
        cyc_d   = '0;
      end
      RUN: begin
        if (bus.core_done_i) begin
          state_d = UNLOAD;
          ct_d    = bus.core_ciphertext_i;
          cyc_d   = '0;
        end else if (timeout) begin
          state_d = IDLE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      UNLOAD: begin
        if (out_fire) begin
          if (wcnt_q == 3'(CT_WORDS - 1)) begin
            state_d = IDLE;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      cyc_q       <= '0;
      key_valid_q <= 1'b0;
      ct_q        <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      cyc_q       <= cyc_d;
      key_valid_q <= key_valid_d;
      ct_q        <= ct_d;
    end
  end

  assign bus.in_ready_o       = in_ready;
  assign bus.out_valid_o      = (state_q == UNLOAD);
  assign bus.out_data_o       = (state_q == UNLOAD) ?
                                ct_q[(CT_WORDS-1-int'(wcnt_q[1:0]))*WORD_W +: WORD_W] : '0;
  assign bus.core_key_o       = key_q;
  assign bus.core_plaintext_o = pt_q;
  assign bus.core_en_o        = (state_q == START) || (state_q == RUN);
  assign bus.core_rst_n_o     = (state_q != START);
  assign bus.busy_o           = (state_q != IDLE);
  assign bus.err_o            = idle_err || timeout;
endmodule

// File: tb/tb_aes_block_loader.sv
// Randomized bench for aes_block_loader: a stand-in AES core plus a stream-level reference model.
module tb_aes_block_loader;
  import aes_loader_pkg::*;

  localparam int TO = 15;
  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam int P_IN = 0, P_START = 1, P_RUN = 2, P_OUT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  aes_block_loader_if bus ();
  aes_block_loader #(.TIMEOUT_CYCLES(TO)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Stand-in cipher: the true FIPS-197 answer for the reference vector, a cheap mix otherwise.
  function automatic logic [127:0] fake_aes(input logic [255:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return {p[95:0], p[127:96]} ^ k[255:128] ^ k[127:0] ^ 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;
  endfunction

  // ---------------- reference model state ----------------
  int ph = P_IN, kind = 0, widx = 0, run_n = 0, oidx = 0;
  bit mkv = 0;
  logic [31:0] mk[8];
  logic [31:0] mp[4];
  logic [127:0] exp_ct = '0;

  function automatic logic [255:0] pack_key();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = mk[i];
    return r;
  endfunction

  function automatic logic [127:0] pack_pt();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[127-32*i -: 32] = mp[i];
    return r;
  endfunction

  // ---------------- observation statistics ----------------
  bit mon_en = 0;
  int cyc_n = 0, rstn_low_cnt = 0, err_cnt = 0, t_start = 0, t_err = 0;
  bit err_prev = 0;
  logic busy_after_err = 1'b1;
  logic [31:0] got[$];
  int core_lat = 5;
  int core_cnt = 0;
  bit rnd_ready = 0;

  always @(negedge clk) if (mon_en) begin
    logic exp_err;
    logic [31:0] d;
    cyc_n++;
    if (err_prev) busy_after_err = bus.busy_o;
    err_prev = bus.err_o;
    if (rst) begin
      chk("rst_out_valid", bus.out_valid_o, 0);
      chk("rst_out_data", bus.out_data_o, 0);
      chk("rst_core_en", bus.core_en_o, 0);
      chk("rst_core_rst_n", bus.core_rst_n_o, 1);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_err", bus.err_o, 0);
      chk("rst_core_key", bus.core_key_o, 0);
      chk("rst_core_pt", bus.core_plaintext_o, 0);
      ph = P_IN; kind = 0; widx = 0; run_n = 0; oidx = 0; mkv = 0; err_prev = 0;
      for (int i = 0; i < 8; i++) mk[i] = '0;
      for (int i = 0; i < 4; i++) mp[i] = '0;
    end else begin
      exp_err = (ph == P_IN && bus.in_valid_i && kind == 0 && !bus.in_key_i && !mkv) ||
                (ph == P_RUN && run_n == TO && !bus.core_done_i);
      chk("in_ready", bus.in_ready_o, ph == P_IN);
      chk("busy", bus.busy_o, !(ph == P_IN && kind == 0));
      chk("core_en", bus.core_en_o, ph == P_START || ph == P_RUN);
      chk("core_rst_n", bus.core_rst_n_o, ph != P_START);
      chk("out_valid", bus.out_valid_o, ph == P_OUT);
      chk("out_data", bus.out_data_o, (ph == P_OUT) ? exp_ct[127-32*oidx -: 32] : 32'h0);
      chk("err", bus.err_o, exp_err);
      chk("core_key", bus.core_key_o, pack_key());
      chk("core_pt", bus.core_plaintext_o, pack_pt());
      if (!bus.core_rst_n_o) begin rstn_low_cnt++; t_start = cyc_n; end
      if (bus.err_o) begin err_cnt++; t_err = cyc_n; end
      if (bus.out_valid_o && bus.out_ready_i) got.push_back(bus.out_data_o);
      case (ph)
        P_IN: if (bus.in_valid_i) begin
          d = bus.in_data_i;
          if (kind == 0) begin
            if (bus.in_key_i) begin kind = 1; mkv = 0; mk[0] = d; widx = 1; end
            else if (mkv) begin kind = 2; mp[0] = d; widx = 1; end
          end else if (kind == 1) begin
            mk[widx] = d; widx++;
            if (widx == 8) begin kind = 0; mkv = 1; end
          end else begin
            mp[widx] = d; widx++;
            if (widx == 4) begin kind = 0; ph = P_START; end
          end
        end
        P_START: begin ph = P_RUN; run_n = 0; end
        P_RUN: begin
          if (bus.core_done_i) begin
            exp_ct = fake_aes(pack_key(), pack_pt()); ph = P_OUT; oidx = 0;
          end else if (run_n == TO) ph = P_IN;
          else run_n++;
        end
        P_OUT: if (bus.out_ready_i) begin
          oidx++;
          if (oidx == 4) ph = P_IN;
        end
        default: ph = P_IN;
      endcase
    end
  end

  // ---------------- AES core stand-in and output sink ----------------
  initial begin
    bus.core_done_i = 1'b0;
    bus.core_ciphertext_i = '0;
    forever begin
      @(posedge clk); #1;
      if (!bus.core_rst_n_o) begin core_cnt = 0; bus.core_done_i = 1'b0; end
      else if (bus.core_en_o) begin
        core_cnt++;
        bus.core_done_i = (core_lat != 0 && core_cnt == core_lat);
      end else bus.core_done_i = 1'b0;
      bus.core_ciphertext_i = bus.core_done_i ? fake_aes(bus.core_key_o, bus.core_plaintext_o)
                                              : {$urandom, $urandom, $urandom, $urandom};
    end
  end

  initial begin
    bus.out_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_word(input logic [31:0] d, input logic k);
    bit acc = 0;
    bus.in_valid_i = 1'b1; bus.in_data_i = d; bus.in_key_i = k;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk); acc = bus.in_ready_o;
      @(posedge clk); #1;
    end
    bus.in_valid_i = 1'b0; bus.in_data_i = $urandom; bus.in_key_i = 1'($urandom_range(0, 1));
    if (!acc) begin
      miscompares++;
      $display("FAIL in_accept: word %0h not accepted, want accept within 200 cycles", d);
    end
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic send_key(input logic [255:0] k);
    for (int i = 0; i < 8; i++) send_word(k[255-32*i -: 32], (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
  endtask

  task automatic send_pt(input logic [127:0] p, input int n);
    for (int i = 0; i < n; i++) send_word(p[127-32*i -: 32], (i == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int n = 0; n < 400 && !idle; n++) begin @(negedge clk); idle = !bus.busy_o; end
    if (!idle) begin
      miscompares++;
      $display("FAIL wait_idle: busy_o stuck at 1, want 0 within 400 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1 rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_fips(input string tag);
    int r0, e0;
    logic [127:0] ct;
    ct = FIPS_CT;
    r0 = rstn_low_cnt; e0 = err_cnt;
    got.delete();
    send_pt(FIPS_PT, 4);
    wait_idle();
    chk({tag, "_count"}, got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk({tag, "_word"}, got[i], ct[127-32*i -: 32]);
    chk({tag, "_rstn_pulses"}, rstn_low_cnt - r0, 1);
    chk({tag, "_no_err"}, err_cnt - e0, 0);
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    int e0, r0;
    logic [127:0] p;
    bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.in_key_i = 1'b0;
    #2 rst = 1'b1; mon_en = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", bus.in_ready_o, 1);
    @(posedge clk); #1;

    // plaintext word with no key loaded
    e0 = err_cnt;
    send_word(32'hdeadbeef, 1'b0);
    @(negedge clk);
    chk("nokey_err_pulses", err_cnt - e0, 1);
    chk("nokey_busy", bus.busy_o, 0);
    chk("nokey_in_ready", bus.in_ready_o, 1);
    @(posedge clk); #1;

    // FIPS-197 vector, then retained key
    core_lat = 5;
    send_key(FIPS_KEY);
    run_fips("fips1");
    core_lat = 3; got.delete(); r0 = rstn_low_cnt;
    p = {$urandom, $urandom, $urandom, $urandom};
    send_pt(p, 4); wait_idle();
    chk("retained_count", got.size(), 4);
    chk("retained_rstn_pulses", rstn_low_cnt - r0, 1);
    rnd_ready = 1;
    run_fips("fips_stall");

    // timeout
    rnd_ready = 0; core_lat = 0; e0 = err_cnt;
    send_pt({$urandom, $urandom, $urandom, $urandom}, 4);
    wait_idle();
    chk("timeout_err_pulses", err_cnt - e0, 1);
    chk("timeout_latency", t_err - t_start, 16);
    chk("busy_after_timeout", busy_after_err, 0);
    core_lat = 7;
    run_fips("fips_after_timeout");

    // done arrives in the very cycle the timeout would fire
    core_lat = TO + 1;
    run_fips("fips_done_vs_timeout");

    // random blocks with random stalls
    rnd_ready = 1;
    for (int b = 0; b < 8; b++) begin
      if ($urandom_range(0, 2) == 0) send_key(rand_key());
      core_lat = $urandom_range(1, TO + 1);
      got.delete();
      send_pt({$urandom, $urandom, $urandom, $urandom}, 4);
      wait_idle();
      chk("rand_count", got.size(), 4);
    end

    // reset after two plaintext words
    send_key(rand_key());
    send_pt({$urandom, $urandom, $urandom, $urandom}, 2);
    do_reset(2);
    e0 = err_cnt;
    send_word($urandom, 1'b0);
    chk("key_dropped_by_reset", err_cnt - e0, 1);
    core_lat = 4;
    send_key(FIPS_KEY);
    run_fips("fips_after_reset");

    // reset in the middle of RUN
    core_lat = 0; e0 = err_cnt;
    send_pt(FIPS_PT, 4);
    repeat (4) @(posedge clk);
    do_reset(2);
    chk("midrun_reset_no_err", err_cnt - e0, 0);
    core_lat = 6;
    send_key(FIPS_KEY);
    run_fips("fips_after_midrun_reset");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
